// File: rtl/key_debounce_multi_if.sv
// Key-pin bundle for the multi-channel debouncer: raw pins in, debounced level
// and event pulses out. The master drives the pins and the slave is the debouncer.
interface key_debounce_multi_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_filter;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output key,
    input  key_filter,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_repeat
  );

  modport slave (
    input  key,
    output key_filter,
    output key_press,
    output key_release,
    output key_long,
    output key_repeat
  );
endinterface

// File: rtl/key_debounce_multi.sv
// NUM_KEYS independent key debouncers. Each channel produces a filtered level
// and registered press, release, long-press and auto-repeat pulses.
module key_debounce_multi #(
  parameter int unsigned NUM_KEYS   = 4,
  parameter int unsigned CNT_MAX    = 1_000_000,
  parameter logic        IDLE_LEVEL = 1'b1,
  parameter int unsigned LONG_MAX   = 50_000_000,
  parameter int unsigned REPEAT_MAX = 10_000_000
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  key_debounce_multi_if.slave kif
);
  localparam int unsigned HOLD_MAX = (LONG_MAX > REPEAT_MAX) ? LONG_MAX : REPEAT_MAX;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 32'd1);
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 32'd1);

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(32'd0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(32'd0);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_MAX - 32'd1);
  localparam logic [HOLD_W-1:0] REP_LAST  =
    HOLD_W'((REPEAT_MAX == 32'd0) ? 32'd0 : (REPEAT_MAX - 32'd1));
  localparam logic ACTIVE_LEVEL = ~IDLE_LEVEL;

  logic [NUM_KEYS-1:0] d0_r, d1_r;
  logic [NUM_KEYS-1:0] filter_r, filter_s;
  logic [NUM_KEYS-1:0] press_r, press_s;
  logic [NUM_KEYS-1:0] release_r, release_s;
  logic [NUM_KEYS-1:0] long_r, long_s;
  logic [NUM_KEYS-1:0] repeat_r, repeat_s;
  logic [NUM_KEYS-1:0] long_done_r, long_done_s;
  logic [CNT_W-1:0]    cnt_r  [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_s  [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_r [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_s [NUM_KEYS];

  // Next-state for debounce counters, filter, events and hold timing per channel
  always_comb begin
    filter_s    = filter_r;
    press_s     = {NUM_KEYS{1'b0}};
    release_s   = {NUM_KEYS{1'b0}};
    long_s      = {NUM_KEYS{1'b0}};
    repeat_s    = {NUM_KEYS{1'b0}};
    long_done_s = long_done_r;
    cnt_s       = cnt_r;
    hold_s      = hold_r;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (d0_r[i] != d1_r[i]) begin
        cnt_s[i] = CNT_LOAD;
      end else if (cnt_r[i] != CNT_ZERO) begin
        cnt_s[i] = cnt_r[i] - CNT_ONE;
      end else begin
        cnt_s[i] = CNT_ZERO;
      end

      if (cnt_r[i] == CNT_ONE) begin
        filter_s[i] = d1_r[i];
        if (d1_r[i] == filter_r[i]) begin
          press_s[i]   = 1'b0;
          release_s[i] = 1'b0;
        end else if (d1_r[i] == ACTIVE_LEVEL) begin
          press_s[i] = 1'b1;
        end else begin
          release_s[i] = 1'b1;
        end
      end else begin
        filter_s[i] = filter_r[i];
      end

      // The press edge itself is hold count zero, so key_long lands LONG_MAX after it
      if (filter_s[i] == IDLE_LEVEL) begin
        hold_s[i]      = HOLD_ZERO;
        long_done_s[i] = 1'b0;
      end else if (filter_r[i] == IDLE_LEVEL) begin
        hold_s[i] = HOLD_ZERO;
      end else if (!long_done_r[i]) begin
        if (hold_r[i] == LONG_LAST) begin
          long_s[i]      = 1'b1;
          long_done_s[i] = 1'b1;
          hold_s[i]      = HOLD_ZERO;
        end else begin
          hold_s[i] = hold_r[i] + HOLD_ONE;
        end
      end else if (REPEAT_MAX != 32'd0) begin
        if (hold_r[i] == REP_LAST) begin
          repeat_s[i] = 1'b1;
          hold_s[i]   = HOLD_ZERO;
        end else begin
          hold_s[i] = hold_r[i] + HOLD_ONE;
        end
      end else begin
        hold_s[i] = HOLD_ZERO;
      end
    end
  end

  // State and output registers with synchronous reset to the idle level
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      d0_r        <= {NUM_KEYS{IDLE_LEVEL}};
      d1_r        <= {NUM_KEYS{IDLE_LEVEL}};
      filter_r    <= {NUM_KEYS{IDLE_LEVEL}};
      press_r     <= {NUM_KEYS{1'b0}};
      release_r   <= {NUM_KEYS{1'b0}};
      long_r      <= {NUM_KEYS{1'b0}};
      repeat_r    <= {NUM_KEYS{1'b0}};
      long_done_r <= {NUM_KEYS{1'b0}};
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt_r[i]  <= CNT_ZERO;
        hold_r[i] <= HOLD_ZERO;
      end
    end else begin
      d0_r        <= kif.key;
      d1_r        <= d0_r;
      filter_r    <= filter_s;
      press_r     <= press_s;
      release_r   <= release_s;
      long_r      <= long_s;
      repeat_r    <= repeat_s;
      long_done_r <= long_done_s;
      cnt_r       <= cnt_s;
      hold_r      <= hold_s;
    end
  end

  assign kif.key_filter  = filter_r;
  assign kif.key_press   = press_r;
  assign kif.key_release = release_r;
  assign kif.key_long    = long_r;
  assign kif.key_repeat  = repeat_r;
endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with CNT_MAX=8, LONG_MAX=20, REPEAT_MAX=5.
// Cycle j counts rising edges after the stimulus point; outputs are read 1 ns after each edge.
module tb_key_debounce_multi;
  localparam int unsigned NK = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   checks   = 0;
  int   failures = 0;

  key_debounce_multi_if #(.NUM_KEYS(NK)) kif ();

  key_debounce_multi #(
    .NUM_KEYS  (NK),
    .CNT_MAX   (8),
    .IDLE_LEVEL(1'b1),
    .LONG_MAX  (20),
    .REPEAT_MAX(5)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .kif      (kif)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // Observed vector: {filter, press, release, long, repeat}
  function automatic logic [19:0] obs();
    return {kif.key_filter, kif.key_press, kif.key_release, kif.key_long, kif.key_repeat};
  endfunction

  task automatic test_reset;
    logic [19:0] exp;
    kif.key   = 4'hF;
    sys_rst_n = 1'b0;
    for (int j = 1; j <= 53; j++) begin
      tick();
      exp = {4'hF, 16'h0000};
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", j, obs(), exp);
      end
      if (j == 3) sys_rst_n = 1'b1;
    end
  endtask

  task automatic test_clean_press;
    logic [19:0] exp;
    kif.key[0] = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      tick();
      exp = {(j >= 10 && j < 50) ? 4'hE : 4'hF,
             (j == 10) ? 4'b0001 : 4'b0000,
             (j == 50) ? 4'b0001 : 4'b0000,
             (j == 30) ? 4'b0001 : 4'b0000,
             (j == 35 || j == 40 || j == 45) ? 4'b0001 : 4'b0000};
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL clean_press cyc=%0d got=%h exp=%h", j, obs(), exp);
      end
      if (j == 40) kif.key[0] = 1'b1;
    end
  endtask

  task automatic test_bounce;
    logic [19:0] exp;
    kif.key[1] = 1'b0;
    for (int j = 1; j <= 90; j++) begin
      tick();
      exp = {(j >= 40 && j < 80) ? 4'hD : 4'hF,
             (j == 40) ? 4'b0010 : 4'b0000,
             (j == 80) ? 4'b0010 : 4'b0000,
             (j == 60) ? 4'b0010 : 4'b0000,
             (j == 65 || j == 70 || j == 75) ? 4'b0010 : 4'b0000};
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL bounce cyc=%0d got=%h exp=%h", j, obs(), exp);
      end
      if (j < 30 && (j % 3) == 0) kif.key[1] = ~kif.key[1];
      if (j == 30) kif.key[1] = 1'b0;
      if (j == 50) kif.key[1] = 1'b1;
      if (j == 55) kif.key[1] = 1'b0;
      if (j == 70) kif.key[1] = 1'b1;
    end
  endtask

  task automatic test_long_repeat;
    logic [19:0] exp;
    kif.key[2] = 1'b0;
    for (int j = 1; j <= 95; j++) begin
      tick();
      exp = {(j >= 10 && j < 80) ? 4'hB : 4'hF,
             (j == 10) ? 4'b0100 : 4'b0000,
             (j == 80) ? 4'b0100 : 4'b0000,
             (j == 30) ? 4'b0100 : 4'b0000,
             (j >= 35 && j <= 75 && (j % 5) == 0) ? 4'b0100 : 4'b0000};
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL long_repeat cyc=%0d got=%h exp=%h", j, obs(), exp);
      end
      if (j == 70) kif.key[2] = 1'b1;
    end
  endtask

  task automatic test_release_before_long;
    logic [19:0] exp;
    kif.key[2] = 1'b0;
    for (int j = 1; j <= 92; j++) begin
      tick();
      exp = {((j >= 10 && j < 25) || (j >= 50 && j < 82)) ? 4'hB : 4'hF,
             (j == 10 || j == 50) ? 4'b0100 : 4'b0000,
             (j == 25 || j == 82) ? 4'b0100 : 4'b0000,
             (j == 70) ? 4'b0100 : 4'b0000,
             (j == 75 || j == 80) ? 4'b0100 : 4'b0000};
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL release_before_long cyc=%0d got=%h exp=%h", j, obs(), exp);
      end
      if (j == 15) kif.key[2] = 1'b1;
      if (j == 40) kif.key[2] = 1'b0;
      if (j == 72) kif.key[2] = 1'b1;
    end
  endtask

  task automatic test_simultaneous_reset;
    logic [19:0] exp;
    kif.key = 4'b0110;
    for (int j = 1; j <= 62; j++) begin
      tick();
      exp = {((j >= 10 && j < 20) || (j >= 32 && j < 50)) ? 4'h6 : 4'hF,
             (j == 10 || j == 32) ? 4'b1001 : 4'b0000,
             (j == 50) ? 4'b1001 : 4'b0000,
             4'b0000,
             4'b0000};
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL simultaneous_reset cyc=%0d got=%h exp=%h", j, obs(), exp);
      end
      if (j == 19) sys_rst_n = 1'b0;
      if (j == 22) sys_rst_n = 1'b1;
      if (j == 40) kif.key = 4'hF;
    end
  endtask

  initial begin
    kif.key   = 4'hF;
    sys_rst_n = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_release_before_long();
    test_simultaneous_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
